dmem_port_adapter: RTL

Memory-side stage directly downstream of the load/store issue FSM. It accepts one load or store request per transaction, registers it, and drives the data-memory port with a one-cycle mask pulse. It aligns and sign-extends returned load data. It returns a single-cycle `dmem_resp` to the FSM. On `move_flush` it drains any in-flight memory access so a stale response never reaches the FSM, and it buffers one request issued during the drain.

---
 rtl/dmem_port_adapter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dmem_port_adapter.sv
// dmem_port_adapter: registers one load/store request from the issue FSM,
// pulses the data-memory port masks for one cycle, formats load data, and
// drains in-flight accesses across a pipeline flush.
module dmem_port_adapter (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_flush,
  input  logic        rqst_valid,
  input  logic        rqst_we,
  input  logic [31:0] rqst_addr,
  input  logic [2:0]  rqst_funct3,
  input  logic [31:0] rqst_wdata,
  output logic        dmem_resp,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT       = 3'd2,
    DRAIN      = 3'd3,
    DRAIN_PEND = 3'd4
  } state_t;

  state_t      state;

  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;

  logic        pend_we;
  logic [31:0] pend_addr;
  logic [2:0]  pend_funct3;
  logic [31:0] pend_wdata;

  logic        start_issue;
  logic        src_we;
  logic [31:0] src_addr;
  logic [2:0]  src_funct3;
  logic [31:0] src_wdata;

  logic [31:0] rdata_shifted;
  logic [31:0] rdata_fmt;

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] b);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << b;
      2'b01:   m = 4'b0011 << b;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Decide whether a new access issues next cycle and where it comes from
  // (direct request, or the request parked during a drain).
  always_comb begin
    start_issue = 1'b0;
    case (state)
      IDLE:       start_issue = rqst_valid && !move_flush;
      DRAIN:      start_issue = !move_flush && mem_resp && rqst_valid;
      DRAIN_PEND: start_issue = !move_flush && mem_resp;
      default:    start_issue = 1'b0;
    endcase
    if (state == DRAIN_PEND) begin
      src_we     = pend_we;
      src_addr   = pend_addr;
      src_funct3 = pend_funct3;
      src_wdata  = pend_wdata;
    end else begin
      src_we     = rqst_we;
      src_addr   = rqst_addr;
      src_funct3 = rqst_funct3;
      src_wdata  = rqst_wdata;
    end
  end

  // Address and store data follow the request register, so they hold until
  // the next issue overwrites it.
  assign mem_addr  = {req_addr[31:2], 2'b00};
  assign mem_wdata = req_wdata << {req_addr[1:0], 3'b000};

  // Completion is combinational with mem_resp; a flush in the same cycle wins.
  assign dmem_resp = ((state == ISSUE) || (state == WAIT)) && mem_resp && !move_flush;

  // Align returned data to the byte lane and extend per funct3.
  always_comb begin
    rdata_shifted = mem_rdata >> {req_addr[1:0], 3'b000};
    case (req_funct3)
      3'b000:  rdata_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  rdata_fmt = {24'd0, rdata_shifted[7:0]};
      3'b001:  rdata_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b101:  rdata_fmt = {16'd0, rdata_shifted[15:0]};
      default: rdata_fmt = rdata_shifted;
    endcase
    load_data = (dmem_resp && !req_we) ? rdata_fmt : 32'd0;
  end

  // Transaction FSM with request/pending registers and one-cycle mask pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_we      <= 1'b0;
      req_addr    <= 32'd0;
      req_funct3  <= 3'd0;
      req_wdata   <= 32'd0;
      pend_we     <= 1'b0;
      pend_addr   <= 32'd0;
      pend_funct3 <= 3'd0;
      pend_wdata  <= 32'd0;
      mem_rmask   <= 4'd0;
      mem_wmask   <= 4'd0;
    end else begin
      mem_rmask <= 4'd0;
      mem_wmask <= 4'd0;
      if (start_issue) begin
        req_we     <= src_we;
        req_addr   <= src_addr;
        req_funct3 <= src_funct3;
        req_wdata  <= src_wdata;
        if (src_we) mem_wmask <= byte_mask(src_funct3, src_addr[1:0]);
        else        mem_rmask <= byte_mask(src_funct3, src_addr[1:0]);
      end
      case (state)
        IDLE: begin
          if (start_issue) state <= ISSUE;
        end
        ISSUE, WAIT: begin
          if (move_flush)    state <= mem_resp ? IDLE : DRAIN;
          else if (mem_resp) state <= IDLE;
          else               state <= WAIT;
        end
        DRAIN: begin
          if (move_flush) begin
            state <= mem_resp ? IDLE : DRAIN;
          end else if (mem_resp) begin
            state <= start_issue ? ISSUE : IDLE;
          end else if (rqst_valid) begin
            pend_we     <= rqst_we;
            pend_addr   <= rqst_addr;
            pend_funct3 <= rqst_funct3;
            pend_wdata  <= rqst_wdata;
            state       <= DRAIN_PEND;
          end
        end
        DRAIN_PEND: begin
          if (move_flush) begin
            pend_we     <= 1'b0;
            pend_addr   <= 32'd0;
            pend_funct3 <= 3'd0;
            pend_wdata  <= 32'd0;
            state       <= mem_resp ? IDLE : DRAIN;
          end else if (mem_resp) begin
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
